// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter states and
// the idle (NOP) values driven onto the bank/address pins.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_B_TERM    = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MREG      = 4'b0000;

  localparam logic [1:0]  NOP_BA   = 2'b11;
  localparam logic [12:0] NOP_ADDR = 13'h1fff;

  localparam int HOLD_CNT_W = 10;

  typedef enum logic [2:0] {
    INIT,
    ARBIT,
    AREF,
    WRITE,
    READ
  } arb_state_t;

  function automatic logic is_grant_state(arb_state_t s);
    return (s == AREF) || (s == WRITE) || (s == READ);
  endfunction

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational select of one sequencer's cmd/ba/addr onto the SDRAM pins,
// keyed on the arbiter state; anything not owned by a sequencer gets NOP.
module sdram_cmd_mux
  import sdram_pkg::*;
(
  input  arb_state_t  state,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  output logic [3:0]  cmd,
  output logic [1:0]  ba,
  output logic [12:0] addr
);

  always_comb begin
    cmd  = CMD_NOP;
    ba   = NOP_BA;
    addr = NOP_ADDR;
    case (state)
      INIT: begin
        cmd  = init_cmd;
        ba   = init_ba;
        addr = init_addr;
      end
      AREF: begin
        cmd  = aref_cmd;
        ba   = aref_ba;
        addr = aref_addr;
      end
      WRITE: begin
        cmd  = wr_cmd;
        ba   = wr_ba;
        addr = wr_addr;
      end
      READ: begin
        cmd  = rd_cmd;
        ba   = rd_ba;
        addr = rd_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: grants refresh, write and read sequencers in turn, holds
// the grant until the owner's end pulse or a hold timeout, and drives the pins.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int END_TIMEOUT = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [3:0]  aref_cmd,
  input  logic [3:0]  wr_cmd,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  init_ba,
  input  logic [1:0]  aref_ba,
  input  logic [1:0]  wr_ba,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] init_addr,
  input  logic [12:0] aref_addr,
  input  logic [12:0] wr_addr,
  input  logic [12:0] rd_addr,
  input  logic        aref_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        aref_end,
  input  logic        wr_end,
  input  logic        rd_end,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic [15:0] sdram_dq_in,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic [15:0] rd_data,
  output logic        timeout_err
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(END_TIMEOUT - 1);

  arb_state_t            state;
  logic                  last_wr;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  grant_end;
  logic [3:0]            mux_cmd;
  logic [1:0]            mux_ba;
  logic [12:0]           mux_addr;

  always_comb begin
    grant_end = 1'b0;
    case (state)
      AREF:    grant_end = aref_end;
      WRITE:   grant_end = wr_end;
      READ:    grant_end = rd_end;
      default: grant_end = 1'b0;
    endcase
  end

  // last_wr is recorded at grant time, so a forced release still alternates
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= INIT;
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      last_wr     <= 1'b0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      case (state)
        INIT: begin
          if (init_end) state <= ARBIT;
        end
        ARBIT: begin
          hold_cnt <= '0;
          if (!init_end) begin
            state <= INIT;
          end else if (aref_req) begin
            state   <= AREF;
            aref_en <= 1'b1;
          end else if (wr_req && (!rd_req || !last_wr)) begin
            state   <= WRITE;
            wr_en   <= 1'b1;
            last_wr <= 1'b1;
          end else if (rd_req) begin
            state   <= READ;
            rd_en   <= 1'b1;
            last_wr <= 1'b0;
          end
        end
        AREF, WRITE, READ: begin
          if (grant_end) begin
            state <= ARBIT;
          end else if (hold_cnt == HOLD_LIMIT) begin
            state       <= ARBIT;
            timeout_err <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  sdram_cmd_mux u_cmd_mux (
    .state     (state),
    .init_cmd  (init_cmd),
    .init_ba   (init_ba),
    .init_addr (init_addr),
    .aref_cmd  (aref_cmd),
    .aref_ba   (aref_ba),
    .aref_addr (aref_addr),
    .wr_cmd    (wr_cmd),
    .wr_ba     (wr_ba),
    .wr_addr   (wr_addr),
    .rd_cmd    (rd_cmd),
    .rd_ba     (rd_ba),
    .rd_addr   (rd_addr),
    .cmd       (mux_cmd),
    .ba        (mux_ba),
    .addr      (mux_addr)
  );

  // Reset overrides the pins combinationally so an aborted grant stops at once
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sys_rst ? CMD_NOP : mux_cmd;
  assign sdram_ba     = sys_rst ? NOP_BA   : mux_ba;
  assign sdram_addr   = sys_rst ? NOP_ADDR : mux_addr;
  assign sdram_cke    = 1'b1;
  assign sdram_dq_oe  = !sys_rst && is_grant_state(state) && (state == WRITE) && wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 16'h0000;
  assign rd_data      = sdram_dq_in;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a per-cycle vector table for grant order
// and pin muxing, plus hand sequences for alternation, DQ, timeout and reset.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  typedef struct {
    bit [6:0] in_bits;
    bit [2:0] exp_en;
    bit [3:0] exp_cmd;
    bit [1:0] exp_ba;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = CMD_PRECHARGE;
  logic [3:0]  aref_cmd = CMD_AREF;
  logic [3:0]  wr_cmd = CMD_WRITE;
  logic [3:0]  rd_cmd = CMD_READ;
  logic [1:0]  init_ba = 2'b00;
  logic [1:0]  aref_ba = 2'b01;
  logic [1:0]  wr_ba = 2'b10;
  logic [1:0]  rd_ba = 2'b00;
  logic [12:0] init_addr = 13'h0400;
  logic [12:0] aref_addr = 13'h0001;
  logic [12:0] wr_addr = 13'h0123;
  logic [12:0] rd_addr = 13'h0abc;
  logic        aref_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic        aref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic [15:0] sdram_dq_in = 16'h0000;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out, rd_data;
  logic        sdram_dq_oe, timeout_err;
  logic [3:0]  pin_cmd;
  logic [2:0]  en_bits;

  int checks = 0;
  int failures = 0;
  vec_t vecs[21];

  assign pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign en_bits = {aref_en, wr_en, rd_en};

  always #5 sys_clk = ~sys_clk;

  sdram_arbiter #(.END_TIMEOUT(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .init_cmd      (init_cmd),
    .aref_cmd      (aref_cmd),
    .wr_cmd        (wr_cmd),
    .rd_cmd        (rd_cmd),
    .init_ba       (init_ba),
    .aref_ba       (aref_ba),
    .wr_ba         (wr_ba),
    .rd_ba         (rd_ba),
    .init_addr     (init_addr),
    .aref_addr     (aref_addr),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .aref_req      (aref_req),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .aref_end      (aref_end),
    .wr_end        (wr_end),
    .rd_end        (rd_end),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data),
    .sdram_dq_in   (sdram_dq_in),
    .aref_en       (aref_en),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .sdram_cke     (sdram_cke),
    .sdram_cs_n    (sdram_cs_n),
    .sdram_ras_n   (sdram_ras_n),
    .sdram_cas_n   (sdram_cas_n),
    .sdram_we_n    (sdram_we_n),
    .sdram_ba      (sdram_ba),
    .sdram_addr    (sdram_addr),
    .sdram_dq_out  (sdram_dq_out),
    .sdram_dq_oe   (sdram_dq_oe),
    .rd_data       (rd_data),
    .timeout_err   (timeout_err)
  );

  function automatic vec_t mk(bit [6:0] b, bit [2:0] e, bit [3:0] c, bit [1:0] ba);
    vec_t v;
    v.in_bits = b;
    v.exp_en  = e;
    v.exp_cmd = c;
    v.exp_ba  = ba;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit order: {init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end}
  task automatic applyStimulus(input bit [6:0] b);
    {init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = b;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // who: 0=aref, 1=write, 2=read, -1=no grant within the budget
  task automatic waitGrant(output int who);
    who = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (aref_en) begin who = 0; break; end
      if (wr_en)   begin who = 1; break; end
      if (rd_en)   begin who = 2; break; end
    end
  endtask

  initial begin
    int who;
    int cycles;

    vecs[0]  = mk(7'b1000000, 3'b000, CMD_PRECHARGE, 2'b00);
    vecs[1]  = mk(7'b1000000, 3'b000, CMD_NOP,       2'b11);
    vecs[2]  = mk(7'b1001000, 3'b000, CMD_NOP,       2'b11);
    vecs[3]  = mk(7'b1000000, 3'b001, CMD_READ,      2'b00);
    vecs[4]  = mk(7'b1000000, 3'b000, CMD_READ,      2'b00);
    vecs[5]  = mk(7'b1000001, 3'b000, CMD_READ,      2'b00);
    vecs[6]  = mk(7'b1111000, 3'b000, CMD_NOP,       2'b11);
    vecs[7]  = mk(7'b1011000, 3'b100, CMD_AREF,      2'b01);
    vecs[8]  = mk(7'b1011100, 3'b000, CMD_AREF,      2'b01);
    vecs[9]  = mk(7'b1011000, 3'b000, CMD_NOP,       2'b11);
    vecs[10] = mk(7'b1001001, 3'b010, CMD_WRITE,     2'b10);
    vecs[11] = mk(7'b1001010, 3'b000, CMD_WRITE,     2'b10);
    vecs[12] = mk(7'b1001000, 3'b000, CMD_NOP,       2'b11);
    vecs[13] = mk(7'b1000000, 3'b001, CMD_READ,      2'b00);
    vecs[14] = mk(7'b1010001, 3'b000, CMD_READ,      2'b00);
    vecs[15] = mk(7'b1010000, 3'b000, CMD_NOP,       2'b11);
    vecs[16] = mk(7'b1000010, 3'b010, CMD_WRITE,     2'b10);
    vecs[17] = mk(7'b0000000, 3'b000, CMD_NOP,       2'b11);
    vecs[18] = mk(7'b0000000, 3'b000, CMD_PRECHARGE, 2'b00);
    vecs[19] = mk(7'b1000000, 3'b000, CMD_PRECHARGE, 2'b00);
    vecs[20] = mk(7'b1000000, 3'b000, CMD_NOP,       2'b11);

    wr_sdram_en   = 1'b1;
    wr_sdram_data = 16'ha5a5;
    tick();
    checkOutput("rst_cmd",     32'(pin_cmd),      32'(CMD_NOP));
    checkOutput("rst_ba",      32'(sdram_ba),     32'(2'b11));
    checkOutput("rst_addr",    32'(sdram_addr),   32'(13'h1fff));
    checkOutput("rst_cke",     32'(sdram_cke),    32'(1'b1));
    checkOutput("rst_dq_oe",   32'(sdram_dq_oe),  32'(1'b0));
    checkOutput("rst_dq_out",  32'(sdram_dq_out), 32'(16'h0000));
    checkOutput("rst_en",      32'(en_bits),      32'(3'b000));
    checkOutput("rst_timeout", 32'(timeout_err),  32'(1'b0));

    sys_rst     = 1'b0;
    wr_sdram_en = 1'b0;
    #1;
    checkOutput("init_cmd",  32'(pin_cmd),    32'(CMD_PRECHARGE));
    checkOutput("init_addr", 32'(sdram_addr), 32'(13'h0400));

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].in_bits);
      #1;
      checkOutput($sformatf("vec%0d_cmd", i), 32'(pin_cmd),  32'(vecs[i].exp_cmd));
      checkOutput($sformatf("vec%0d_ba", i),  32'(sdram_ba), 32'(vecs[i].exp_ba));
      checkOutput($sformatf("vec%0d_en", i),  32'(en_bits),  32'(vecs[i].exp_en));
      tick();
    end

    // Both requests held: write wins first after reset, then strict alternation
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    applyStimulus(7'b1011000);
    for (int g = 0; g < 8; g++) begin
      waitGrant(who);
      checkOutput($sformatf("alt_grant%0d", g), 32'(who), (g % 2 == 0) ? 32'd1 : 32'd2);
      if (who == 1) wr_end = 1'b1;
      if (who == 2) rd_end = 1'b1;
      tick();
      wr_end = 1'b0;
      rd_end = 1'b0;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;

    wr_req = 1'b1;
    waitGrant(who);
    checkOutput("dq_wr_grant", 32'(who), 32'd1);
    wr_req        = 1'b0;
    wr_sdram_en   = 1'b1;
    wr_sdram_data = 16'ha5a5;
    #1;
    checkOutput("dq_wr_oe",   32'(sdram_dq_oe),  32'(1'b1));
    checkOutput("dq_wr_out",  32'(sdram_dq_out), 32'(16'ha5a5));
    checkOutput("dq_wr_addr", 32'(sdram_addr),   32'(13'h0123));
    wr_sdram_en = 1'b0;
    #1;
    checkOutput("dq_wr_oe_off",  32'(sdram_dq_oe),  32'(1'b0));
    checkOutput("dq_wr_out_off", 32'(sdram_dq_out), 32'(16'h0000));
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    checkOutput("pre_timeout_err", 32'(timeout_err), 32'(1'b0));

    rd_req = 1'b1;
    waitGrant(who);
    checkOutput("dq_rd_grant", 32'(who), 32'd2);
    rd_req      = 1'b0;
    wr_sdram_en = 1'b1;
    sdram_dq_in = 16'h3c5a;
    #1;
    checkOutput("dq_rd_oe",   32'(sdram_dq_oe),  32'(1'b0));
    checkOutput("dq_rd_out",  32'(sdram_dq_out), 32'(16'h0000));
    checkOutput("dq_rd_data", 32'(rd_data),      32'(16'h3c5a));
    wr_sdram_en = 1'b0;

    // rd_end never arrives: bus must be reclaimed after 16 cycles in READ
    cycles = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (pin_cmd == CMD_NOP) break;
      cycles++;
    end
    checkOutput("timeout_cycles", 32'(cycles),      32'd16);
    checkOutput("timeout_err",    32'(timeout_err), 32'(1'b1));

    wr_req = 1'b1;
    waitGrant(who);
    checkOutput("rstmid_grant", 32'(who), 32'd1);
    wr_req        = 1'b0;
    wr_sdram_en   = 1'b1;
    wr_sdram_data = 16'ha5a5;
    #1;
    checkOutput("rstmid_oe_before", 32'(sdram_dq_oe), 32'(1'b1));
    sys_rst = 1'b1;
    #1;
    checkOutput("rstmid_cmd",    32'(pin_cmd),      32'(CMD_NOP));
    checkOutput("rstmid_ba",     32'(sdram_ba),     32'(2'b11));
    checkOutput("rstmid_addr",   32'(sdram_addr),   32'(13'h1fff));
    checkOutput("rstmid_oe",     32'(sdram_dq_oe),  32'(1'b0));
    checkOutput("rstmid_dq_out", 32'(sdram_dq_out), 32'(16'h0000));
    checkOutput("rstmid_cke",    32'(sdram_cke),    32'(1'b1));
    tick();
    checkOutput("rstmid_timeout", 32'(timeout_err), 32'(1'b0));
    checkOutput("rstmid_en",      32'(en_bits),     32'(3'b000));
    sys_rst     = 1'b0;
    wr_sdram_en = 1'b0;
    #1;
    checkOutput("rstmid_release_cmd", 32'(pin_cmd), 32'(CMD_PRECHARGE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Arbitrates the single SDRAM command/data bus among the init, auto-refresh, write and read sequencers of the SDRAM controller. Each sequencer drives its own {cs_n,ras_n,cas_n,we_n}/ba/addr, and this block muxes exactly one of them onto the device pins. It grants refresh, write and read, then holds the grant until that sequencer's end pulse. The block sits between the sequencers and the SDRAM pad ring, all in the 100 MHz `sys_clk` domain.

## Interface
- `END_TIMEOUT`, 1023: max cycles a granted sequencer may hold the bus before a forced release.
- `sys_clk`  in  1  system/SDRAM command clock, 100 MHz
- `sys_rst`  in  1  synchronous, active-high reset
- `init_end`  in  1  init sequencer done (level)
- `init_cmd`, `aref_cmd`, `wr_cmd`, `rd_cmd`  in  4 each  {cs_n,ras_n,cas_n,we_n} from each sequencer
- `init_ba`, `aref_ba`, `wr_ba`, `rd_ba`  in  2 each  bank address
- `init_addr`, `aref_addr`, `wr_addr`, `rd_addr`  in  13 each  A12–A0
- `aref_req`, `wr_req`, `rd_req`  in  1 each  service requests (level, held until granted)
- `aref_end`, `wr_end`, `rd_end`  in  1 each  one-cycle completion pulses
- `wr_sdram_en`  in  1  write data valid on DQ
- `wr_sdram_data`  in  16  write data
- `sdram_dq_in`  in  16  DQ input from pad
- `aref_en`, `wr_en`, `rd_en`  out  1 each  one-cycle start pulse to the granted sequencer
- `sdram_cke`  out  1  clock enable
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  out  1 each  command pins
- `sdram_ba`  out  2  bank pins
- `sdram_addr`  out  13  address pins
- `sdram_dq_out`  out  16  DQ output
- `sdram_dq_oe`  out  1  DQ output enable
- `rd_data`  out  16  read data to read sequencer
- `timeout_err`  out  1  sticky, set on forced release

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ.
- INIT:
  - Pins follow the `init_*` inputs.
  - When `init_end`=1, go to ARBIT.
- ARBIT:
  - Pins drive NOP (0111), ba=2'b11, addr=13'h1fff.
  - Priority: `aref_req` wins. Otherwise, if only one of `wr_req`/`rd_req` is high, it wins.
  - If both are high, serve the one not served last (1-bit `last_wr` flag, reset 0, so write wins first).
  - The winning transition registers the matching `*_en`=1 for exactly one cycle (the first cycle in the new state).
  - `init_end`=0 in ARBIT returns to INIT.
- AREF/WRITE/READ:
  - Pins follow the granted sequencer's cmd/ba/addr.
  - Matching `*_end`=1 returns to ARBIT next cycle.
  - Requests arriving meanwhile stay pending. `*_end` from non-granted sequencers is ignored.
- DQ:
  - `sdram_dq_oe` = (state==WRITE) & `wr_sdram_en`.
  - `sdram_dq_out` = `wr_sdram_data` when `sdram_dq_oe` is high, else 0.
  - `rd_data` = `sdram_dq_in` (combinational pass-through).
- Timeout:
  - A 10-bit hold counter clears on entry to AREF/WRITE/READ and increments each cycle there.
  - On reaching `END_TIMEOUT` without an end pulse: return to ARBIT, set `timeout_err` (cleared only by reset).
  - `last_wr` still updates on a forced release.
- `sdram_cke` is constant 1 after reset.

## Timing
- Reset (`sys_rst`=1 at an edge): state=INIT, all `*_en`=0, `last_wr`=0, counter=0, `timeout_err`=0.
- While `sys_rst` is high, outputs are forced:
  - cmd pins=0111, ba=2'b11, addr=13'h1fff, `sdram_cke`=1.
  - `sdram_dq_oe`=0, `sdram_dq_out`=0.
- Reset mid-operation aborts the grant immediately; no PRECHARGE is issued by this block.
- Pin mux is combinational from registered state: zero added latency on sequencer commands.
- Request to start: `*_req` sampled high in ARBIT at edge N gives state change and `*_en`=1 during cycle N+1. The sequencer leaves its idle state at edge N+2.
- End to next grant: `*_end` at edge M gives ARBIT in cycle M+1, next `*_en` in cycle M+2. At least one NOP cycle always separates grants.
- A `*_req` asserted in the same cycle as the current `*_end` is considered in the following ARBIT cycle.
- Grant decision uses only request levels sampled in ARBIT; requests deasserted before then are dropped.

## Structure
- Shared package `sdram_pkg`:
  - Command encodings NOP/ACTIVE/READ/WRITE/B_TERM/PRECHARGE/AREF/MREG.
  - Arbiter state encodings.
  - NOP defaults ba=2'b11, addr=13'h1fff.
- One sub-module, `sdram_cmd_mux`: purely combinational 4-way cmd/ba/addr select keyed on arbiter state, with NOP default.
- FSM, grant/`last_wr` logic and timeout counter stay in `sdram_arbiter`.

## Test plan
- Reset release with `init_cmd`=0010: pins show 0010. After `init_end`↑, the next cycle shows 0111 / ba=3 / addr=1fff.
- `rd_req`=1 alone: `rd_en` pulses 1 cycle; pins track `rd_cmd` (0011, 0101, 0110, 0010); after `rd_end`, 0111 appears for ≥1 cycle.
- `aref_req`, `wr_req`, `rd_req` all raised together: grant order is aref, then write, then read. Each `*_en` comes exactly one cycle after the prior ARBIT entry.
- `wr_req` and `rd_req` held permanently high, ends pulsed promptly: grants alternate W, R, W, R for 8 grants.
- During WRITE with `wr_sdram_en`=1 and data 16'hA5A5: `sdram_dq_oe`=1 and `sdram_dq_out`=A5A5. In READ, `sdram_dq_oe`=0 and `rd_data` equals `sdram_dq_in`.
- Grant read, never pulse `rd_end`, `END_TIMEOUT`=16: returns to ARBIT after 16 cycles and `timeout_err`=1. Assert `sys_rst` mid-WRITE: pins are 0111 the same cycle and `timeout_err`=0.
